// File: rtl/alu_mc.sv
// Registered, multi-cycle execute ALU: AND/OR/ADD/SUB/SLT plus an optional iterative multiply.
// Build option: define ALU_MUL_EN to include the shift-add multiplier (op 1000) and its MUL/HOLD states.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             set,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             add_ovf_s;
  logic             less_s;
  logic [WIDTH-1:0] op_res_s;
  logic             op_cout_s;
  logic             op_ovf_s;
  logic             op_set_s;
  logic             op_err_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             overflow_r;
  logic             zero_r;
  logic             set_r;
  logic             err_r;

  logic             out_free_s;
  logic             idle_s;
  logic             mul_op_s;
  logic             accept_s;
  logic             single_ld_s;
  logic             hold_wr_s;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_ovf_s;

  // Shared adder: b is inverted and carry-in set for SUB/SLT.
  assign b_op_s                = op[2] ? ~b : b;
  assign {carry_s, sum_s}      = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, op[2]};
  assign add_ovf_s             = (a[WIDTH-1] == b_op_s[WIDTH-1]) & (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign less_s                = sum_s[WIDTH-1] ^ add_ovf_s;

  assign out_free_s  = ~out_valid_r | out_ready;
  assign in_ready    = idle_s & out_free_s & ~reset;
  assign accept_s    = in_valid & in_ready;
  assign single_ld_s = accept_s & ~mul_op_s;

  // Single-cycle result and flag selection.
  always_comb begin
    op_res_s  = {WIDTH{1'b0}};
    op_cout_s = 1'b0;
    op_ovf_s  = 1'b0;
    op_set_s  = 1'b0;
    op_err_s  = 1'b0;
    if (op[3] == 1'b0) begin
      op_cout_s = carry_s;
      op_ovf_s  = add_ovf_s;
      op_set_s  = less_s;
      case (op[1:0])
        2'b00:   op_res_s = a & b_op_s;
        2'b01:   op_res_s = a | b_op_s;
        2'b10:   op_res_s = sum_s;
        2'b11:   op_res_s = {{(WIDTH-1){1'b0}}, less_s};
        default: op_res_s = {WIDTH{1'b0}};
      endcase
    end else begin
      op_err_s = 1'b1;
    end
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] mplier_ext_s;

  assign idle_s       = (state_r == S_IDLE);
  assign mul_op_s     = (op == 4'b1000);
  assign hold_wr_s    = (state_r == S_HOLD) & out_free_s;
  assign mplier_ext_s = {{WIDTH{1'b0}}, mplier_r};
  assign mul_res_s    = acc_r[WIDTH-1:0];
  assign mul_ovf_s    = |acc_r[2*WIDTH-1:WIDTH];
  assign busy         = busy_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s & mul_op_s) begin
          state_nxt_s = S_MUL;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_nxt_s = S_HOLD;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      S_HOLD: begin
        if (out_free_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Shift-add datapath; runs all WIDTH iterations regardless of operand values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (accept_s & mul_op_s) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
    end else if (state_r == S_MUL) begin
      if (mcand_r[0]) begin
        acc_r <= acc_r + (mplier_ext_s << cnt_r);
      end
      mcand_r <= mcand_r >> 1;
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else if (hold_wr_s) begin
      busy_r <= 1'b0;
    end
  end
`else
  assign idle_s    = 1'b1;
  assign mul_op_s  = 1'b0;
  assign hold_wr_s = 1'b0;
  assign mul_res_s = {WIDTH{1'b0}};
  assign mul_ovf_s = 1'b0;
  assign busy      = 1'b0;
`endif

  // Output register: loaded by a single-cycle accept or the multiply write-back, cleared on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      set_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (single_ld_s) begin
      out_valid_r <= 1'b1;
      result_r    <= op_res_s;
      cout_r      <= op_cout_s;
      overflow_r  <= op_ovf_s;
      zero_r      <= (op_res_s == {WIDTH{1'b0}}) & ~op_err_s;
      set_r       <= op_set_s;
      err_r       <= op_err_s;
    end else if (hold_wr_s) begin
      out_valid_r <= 1'b1;
      result_r    <= mul_res_s;
      cout_r      <= 1'b0;
      overflow_r  <= mul_ovf_s;
      zero_r      <= (mul_res_s == {WIDTH{1'b0}});
      set_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (out_valid_r & out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;
  assign set       = set_r;
  assign err       = err_r;

endmodule
